comp_arbiter: RTL and testbench

- Time-shares one registered WIDTH-bit magnitude comparator (greater/equal/smaller) among NREQ requesters.
- Uses round-robin arbitration and a per-requester req/gnt handshake.
- Returns a one-hot g/e/s result tagged with the requester index.
- Sits between multiple client blocks needing occasional compares and the single shared comparator datapath.

---
 rtl/comp_arbiter.sv | 110 +++++++++++
 tb/tb_comp_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/comp_arbiter.sv
// rtl/comp_arbiter.sv - round-robin time-shared registered magnitude comparator
module comp_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_bus,
    input  logic [NREQ*WIDTH-1:0] b_bus,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        res_id,
    output logic                  g,
    output logic                  e,
    output logic                  s
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    win_q;
    logic [IDW-1:0]    pick;
    logic              found;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  a_pick, b_pick;
    logic [NREQ-1:0]   gnt_q;

    // Search distance i from the pointer; the first requester reached wins.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        a_pick = '0;
        b_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (((int'(ptr) + i) % NREQ) == j)) begin
                    found  = 1'b1;
                    pick   = IDW'(j);
                    a_pick = a_bus[j*WIDTH +: WIDTH];
                    b_pick = b_bus[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_CMP;
            S_CMP:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
        gnt  = gnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            win_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            gnt_q  <= '0;
            res_id <= '0;
            g      <= 1'b0;
            e      <= 1'b0;
            s      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        a_q   <= a_pick;
                        b_q   <= b_pick;
                        win_q <= pick;
                        gnt_q <= NREQ'(1) << pick;
                    end
                end
                S_CMP: begin
                    gnt_q  <= '0;
                    g      <= (a_q > b_q);
                    e      <= (a_q == b_q);
                    s      <= (a_q < b_q);
                    res_id <= win_q;
                end
                S_DONE: begin
                    ptr <= (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_arbiter.sv
// tb/tb_comp_arbiter.sv - directed self-checking bench for comp_arbiter
module tb_comp_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        res_id;
    logic                  g, e, s;

    int checks;
    int errors;

    comp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a_bus  (a_bus),
        .b_bus  (b_bus),
        .gnt    (gnt),
        .busy   (busy),
        .done   (done),
        .res_id (res_id),
        .g      (g),
        .e      (e),
        .s      (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_bus[idx*WIDTH +: WIDTH] = a;
        b_bus[idx*WIDTH +: WIDTH] = b;
    endtask

    task automatic check_res(input string tag, input logic eg, input logic ee,
                             input logic es, input logic [IDW-1:0] eid);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_ges"}, 32'({g, e, s}), 32'({eg, ee, es}));
        check({tag, "_id"}, 32'(res_id), 32'(eid));
        check({tag, "_gnt0"}, 32'(gnt), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_id"}, 32'(res_id), 32'd0);
        check({tag, "_ges"}, 32'({g, e, s}), 32'd0);
    endtask

    logic [3:0] rr_exp_ges [NREQ];
    int done_seen;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        a_bus  = '0;
        b_bus  = '0;

        // reset then idle
        tick();
        tick();
        check_cleared("reset");
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done || busy || gnt != 0) done_seen++;
        end
        check("idle_quiet", 32'(done_seen), 32'd0);
        check_cleared("idle");

        // single compare, requester 2: A > B
        set_ops(2, 4'hA, 4'h3);
        req = 4'b0100;
        tick();
        check("s1_gnt", 32'(gnt), 32'b0100);
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_nodone", 32'(done), 32'd0);
        req = '0;
        tick();
        check_res("s1", 1'b1, 1'b0, 1'b0, 2'd2);
        tick();
        check("s1_done_drop", 32'(done), 32'd0);
        check("s1_idle", 32'(busy), 32'd0);
        check("s1_hold", 32'({g, e, s, res_id}), 32'({3'b100, 2'd2}));

        // A == B
        set_ops(2, 4'h7, 4'h7);
        req = 4'b0100;
        tick();
        check("s2_gnt", 32'(gnt), 32'b0100);
        req = '0;
        tick();
        check_res("s2", 1'b0, 1'b1, 1'b0, 2'd2);
        tick();

        // A < B at the extremes
        set_ops(2, 4'h0, 4'hF);
        req = 4'b0100;
        tick();
        check("s3_gnt", 32'(gnt), 32'b0100);
        req = '0;
        tick();
        check_res("s3", 1'b0, 1'b0, 1'b1, 2'd2);
        tick();

        // reset so requester 0 is on top again
        rst_n = 1'b0;
        tick();
        check_cleared("rst2");
        rst_n = 1'b1;

        // round-robin with all requesters active
        set_ops(0, 4'h1, 4'h2); rr_exp_ges[0] = 4'b0001;
        set_ops(1, 4'h5, 4'h5); rr_exp_ges[1] = 4'b0010;
        set_ops(2, 4'hF, 4'h0); rr_exp_ges[2] = 4'b0100;
        set_ops(3, 4'h3, 4'h9); rr_exp_ges[3] = 4'b0001;
        req = 4'b1111;
        for (int n = 0; n < NREQ; n++) begin
            tick();
            check($sformatf("rr%0d_gnt", n), 32'(gnt), 32'(1 << n));
            tick();
            check_res($sformatf("rr%0d", n), rr_exp_ges[n][2], rr_exp_ges[n][1],
                      rr_exp_ges[n][0], IDW'(n));
            tick();
            check($sformatf("rr%0d_idle", n), 32'({busy, done}), 32'd0);
        end

        // wrap past 3 and skip idle requesters
        req = 4'b1010;
        tick();
        check("wr1_gnt", 32'(gnt), 32'b0010);
        tick();
        check_res("wr1", 1'b0, 1'b1, 1'b0, 2'd1);
        tick();
        tick();
        check("wr3_gnt", 32'(gnt), 32'b1000);
        tick();
        check_res("wr3", 1'b0, 1'b0, 1'b1, 2'd3);
        tick();

        // operand change after grant must not affect result
        set_ops(0, 4'h9, 4'h5);
        req = 4'b0001;
        tick();
        check("os_gnt", 32'(gnt), 32'b0001);
        set_ops(0, 4'h1, 4'h5);
        req = '0;
        tick();
        check_res("os", 1'b1, 1'b0, 1'b0, 2'd0);
        tick();

        // reset during CMP discards the compare
        set_ops(0, 4'h2, 4'h8);
        req = 4'b0001;
        tick();
        check("mr_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req = '0;
        #1;
        check_cleared("mr_async");
        done_seen = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (done) done_seen++;
        end
        check("mr_nodone", 32'(done_seen), 32'd0);
        check_cleared("mr_hold");

        // pointer back at requester 0 after reset
        rst_n = 1'b1;
        set_ops(1, 4'hC, 4'h4);
        req = 4'b0011;
        tick();
        check("pr_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        check_res("pr", 1'b0, 1'b0, 1'b1, 2'd0);
        tick();

        req = 4'b0010;
        tick();
        check("r1_gnt", 32'(gnt), 32'b0010);
        req = '0;
        tick();
        check_res("r1", 1'b1, 1'b0, 1'b0, 2'd1);
        tick();
        check("r1_idle", 32'({busy, done, gnt}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
